// File: rtl/info_frame_builder.sv
// Purpose: CEA-861 InfoFrame source; shadow payload buffer, sequential checksum, atomic publish to active sub-packets.
// Latency: commit at edge 0 -> new sub visible after edge LENGTH+1, plus one cycle per cycle of lock held in SWAP.
// Backpressure: wr_ready low while busy (writes dropped); commits while busy collapse into one follow-up pass.
module info_frame_builder #(
    parameter logic [6:0] TYPE    = 7'd4,
    parameter logic [7:0] VERSION = 8'd1,
    parameter logic [4:0] LENGTH  = 5'd10
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    input  logic             commit,
    input  logic             lock,
    output logic             busy,
    output logic             frame_valid,
    output logic [23:0]      header,
    output logic [3:0][55:0] sub
);

    // Payload beyond 27 bytes cannot fit the four 7-byte sub-packets.
    if (LENGTH < 5'd1 || LENGTH > 5'd27) begin : g_bad_length
        $error("info_frame_builder: LENGTH must be in 1..27");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] SWAP = 2'd2;

    localparam logic [7:0] HB0     = {1'b1, TYPE};
    localparam logic [7:0] HB2     = {3'b0, LENGTH};
    localparam logic [7:0] HDR_SUM = HB0 + VERSION + HB2;

    logic [1:0] state;
    logic [7:0] acc;
    logic [4:0] idx;
    logic       pending;
    logic [7:0] shadow [1:27];
    logic [7:0] active [0:27];

    logic wr_accept;

    assign header    = {HB2, VERSION, HB0};
    assign wr_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign wr_accept = wr_en && wr_ready && (wr_addr != 5'd0) && (wr_addr <= LENGTH);

    // Shadow buffer: software writes land here only while idle so the checksum pass sees stable data.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            for (int i = 1; i <= 27; i++) begin
                shadow[i] <= 8'd0;
            end
        end else if (wr_accept) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    // Control FSM: one payload byte summed per CALC cycle, publish in SWAP when the scheduler releases lock.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= 8'd0;
            idx         <= 5'd0;
            pending     <= 1'b0;
            frame_valid <= 1'b0;
            for (int i = 0; i <= 27; i++) begin
                active[i] <= 8'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (commit) begin
                        state <= CALC;
                        acc   <= HDR_SUM;
                        idx   <= 5'd1;
                    end
                end
                CALC: begin
                    if (commit) begin
                        pending <= 1'b1;
                    end
                    acc <= acc + shadow[idx];
                    idx <= idx + 5'd1;
                    if (idx == LENGTH) begin
                        state <= SWAP;
                    end
                end
                SWAP: begin
                    if (lock) begin
                        if (commit) begin
                            pending <= 1'b1;
                        end
                    end else begin
                        // Whole active frame is rewritten on a single edge so the scheduler never sees a mix.
                        active[0] <= 8'd0 - acc;
                        for (int i = 1; i <= 27; i++) begin
                            active[i] <= (i <= int'(LENGTH)) ? shadow[i] : 8'd0;
                        end
                        frame_valid <= 1'b1;
                        if (pending || commit) begin
                            state   <= CALC;
                            acc     <= HDR_SUM;
                            idx     <= 5'd1;
                            pending <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pack the active bytes into sub-packets, PB(7i) in the least significant byte of sub[i].
    always_comb begin
        sub = '0;
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 7; b++) begin
                sub[s][b*8 +: 8] = active[s*7 + b];
            end
        end
    end

endmodule

// File: tb/tb_info_frame_builder.sv
module tb_info_frame_builder;

    logic             clk_pixel = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             wr_ready;
    logic             commit;
    logic             lock;
    logic             busy;
    logic             frame_valid;
    logic [23:0]      header;
    logic [3:0][55:0] sub;

    int tests = 0;
    int fails = 0;
    int cnt;

    always #5 clk_pixel = ~clk_pixel;

    info_frame_builder #(.TYPE(7'd4), .VERSION(8'd1), .LENGTH(5'd10)) dut (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .commit      (commit),
        .lock        (lock),
        .busy        (busy),
        .frame_valid (frame_valid),
        .header      (header),
        .sub         (sub)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
    task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk_pixel);
        wr_en = 1'b0;
    endtask

    // Pulse commit, then count sampled busy cycles until idle, bounded.
    task automatic commit_and_count(output int n);
        commit = 1'b1;
        @(negedge clk_pixel);
        commit = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk_pixel);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; lock = 1'b0;
        repeat (2) @(negedge clk_pixel);
        reset = 1'b0;
        @(negedge clk_pixel);

        // Reset state
        check("rst_header", 64'(header), 64'h0A0184);
        for (int i = 0; i < 4; i++) check($sformatf("rst_sub%0d", i), 64'(sub[i]), 64'h0);
        check("rst_frame_valid", 64'(frame_valid), 64'h0);
        check("rst_wr_ready", 64'(wr_ready), 64'h1);
        check("rst_busy", 64'(busy), 64'h0);

        // Single byte, no lock: busy 11 cycles, checksum 0x70
        write_byte(5'd1, 8'h01);
        commit_and_count(cnt);
        check("t1_busy_cycles", 64'(cnt), 64'd11);
        check("t1_sub0", 64'(sub[0]), 64'h00000000000170);
        for (int i = 1; i < 4; i++) check($sformatf("t1_sub%0d", i), 64'(sub[i]), 64'h0);
        check("t1_frame_valid", 64'(frame_valid), 64'h1);

        // PB4=03 added, lock high for 5 SWAP cycles
        write_byte(5'd4, 8'h03);
        commit = 1'b1; lock = 1'b1;
        @(negedge clk_pixel);            // after edge 0
        commit = 1'b0;
        repeat (10) @(negedge clk_pixel); // after edge 10: in SWAP
        check("t2_busy_in_swap", 64'(busy), 64'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_pixel);        // after edges 11..15 with lock high
            check($sformatf("t2_hold_sub0_%0d", k), 64'(sub[0]), 64'h00000000000170);
        end
        lock = 1'b0;
        @(negedge clk_pixel);            // edge 16 swaps
        check("t2_sub0", 64'(sub[0]), 64'h0000030000016D);
        check("t2_busy_done", 64'(busy), 64'h0);

        // Out-of-range writes are dropped
        write_byte(5'd0, 8'hFF);
        write_byte(5'd11, 8'hFF);
        write_byte(5'd27, 8'hFF);
        commit_and_count(cnt);
        check("drop_busy_cycles", 64'(cnt), 64'd11);
        check("drop_sub0", 64'(sub[0]), 64'h0000030000016D);
        check("drop_sub1", 64'(sub[1]), 64'h0);
        check("drop_sub3", 64'(sub[3]), 64'h0);

        // Write during CALC is refused and not stored
        commit = 1'b1;
        @(negedge clk_pixel);
        commit = 1'b0;
        @(negedge clk_pixel);
        check("calc_wr_ready", 64'(wr_ready), 64'h0);
        write_byte(5'd2, 8'h55);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk_pixel);
        end
        check("calc_wr_sub0", 64'(sub[0]), 64'h0000030000016D);
        check("calc_wr_ready_idle", 64'(wr_ready), 64'h1);

        // Two commits during CALC collapse into one extra pass, busy continuous
        commit = 1'b1;
        @(negedge clk_pixel);
        commit = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            commit = (cnt == 2 || cnt == 4);
            @(negedge clk_pixel);
        end
        commit = 1'b0;
        check("dbl_busy_cycles", 64'(cnt), 64'd22);
        check("dbl_sub0", 64'(sub[0]), 64'h0000030000016D);
        repeat (3) @(negedge clk_pixel);
        check("dbl_no_third_pass", 64'(busy), 64'h0);

        // Reset 3 cycles into CALC aborts with no swap
        write_byte(5'd2, 8'h22);
        commit = 1'b1;
        @(negedge clk_pixel);
        commit = 1'b0;
        repeat (3) @(negedge clk_pixel);
        reset = 1'b1;
        @(negedge clk_pixel);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_frame_valid", 64'(frame_valid), 64'h0);
        check("abort_wr_ready", 64'(wr_ready), 64'h1);
        check("abort_sub0", 64'(sub[0]), 64'h0);
        repeat (15) @(negedge clk_pixel);
        check("abort_no_swap_sub0", 64'(sub[0]), 64'h0);
        check("abort_no_swap_fv", 64'(frame_valid), 64'h0);
        check("abort_header", 64'(header), 64'h0A0184);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
